// File: rtl/bf16_subtractor_seq.sv
// bf16_subtractor_seq: multi-cycle bf16 a - b with full post-cancellation normalization and RNE rounding
module bf16_subtractor_seq #(
  parameter int MAX_NORM_SHIFT = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ALIGN, OP, NORM, ROUND, DONE} state_t;
  localparam logic [3:0] MAX_SH = 4'(MAX_NORM_SHIFT);
  state_t state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [10:0] big_q, big_d, sml_q, sml_d;
  logic [8:0] exp_q, exp_d;
  logic sign_q, sign_d, sub_q, sub_d;
  logic [3:0] nsh_q, nsh_d;
  logic nb, a_inf, b_inf, a_zero, b_zero, a_big, special, inc;
  logic [8:0] ea, eb, ed, exp_r;
  logic [10:0] sa, sb, s_sml, mask, sml_al;
  logic [11:0] sum;
  logic [7:0] rnd;
  logic [15:0] spec_res, rnd_res;
  assign nb = ~b_q[15];
  assign ea = {1'b0, a_q[14:7]};
  assign eb = {1'b0, b_q[14:7]};
  assign a_inf = a_q[14:7] == 8'hFF;
  assign b_inf = b_q[14:7] == 8'hFF;
  assign a_zero = ea == 9'd0;
  assign b_zero = eb == 9'd0;
  assign special = a_inf | b_inf | a_zero | b_zero;
  assign spec_res = a_inf ? a_q : b_inf ? {nb, b_q[14:0]} :
                    a_zero ? (b_zero ? 16'h0000 : {nb, b_q[14:0]}) : a_q;
  assign a_big = a_q[14:0] >= b_q[14:0];
  assign sa = {1'b1, a_q[6:0], 3'b000};
  assign sb = {1'b1, b_q[6:0], 3'b000};
  assign s_sml = a_big ? sb : sa;
  assign ed = a_big ? ea - eb : eb - ea;
  // bits shifted past the sticky position collapse into S
  assign mask = ~(11'h7FF << ed);
  assign sml_al = ed >= 9'd11 ? 11'd1 : (s_sml >> ed) | {10'd0, |(s_sml & mask)};
  assign sum = sub_q ? {1'b0, big_q} - {1'b0, sml_q} : {1'b0, big_q} + {1'b0, sml_q};
  assign inc = big_q[2] & (big_q[1] | big_q[0] | big_q[3]);
  // an 8-bit wrap to zero means the mantissa overflowed into the next binade
  assign rnd = big_q[10:3] + {7'd0, inc};
  assign exp_r = exp_q + {8'd0, ~rnd[7]};
  assign rnd_res = exp_r >= 9'd255 ? {sign_q, 8'hFF, 7'd0} : {sign_q, exp_r[7:0], rnd[6:0]};
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    big_d = big_q;
    sml_d = sml_q;
    exp_d = exp_q;
    sign_d = sign_q;
    sub_d = sub_q;
    nsh_d = nsh_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        state_d = ALIGN;
      end
      ALIGN: begin
        state_d = special ? DONE : OP;
        diff_d = special ? spec_res : diff_q;
        big_d = a_big ? sa : sb;
        sml_d = sml_al;
        exp_d = a_big ? ea : eb;
        sign_d = a_big ? a_q[15] : nb;
        sub_d = a_q[15] != nb;
      end
      OP: begin
        nsh_d = 4'd0;
        if (sum == 12'd0) begin
          diff_d = 16'h0000;
          state_d = DONE;
        end else if (sum[11]) begin
          big_d = {sum[11:2], sum[1] | sum[0]};
          exp_d = exp_q + 9'd1;
          state_d = ROUND;
        end else begin
          big_d = sum[10:0];
          state_d = sum[10] ? ROUND : NORM;
        end
      end
      NORM: begin
        big_d = big_q << 1;
        exp_d = exp_q - 9'd1;
        nsh_d = nsh_q + 4'd1;
        if (exp_q <= 9'd1 || nsh_q >= MAX_SH) begin
          diff_d = 16'h0000;
          state_d = DONE;
        end else if (big_q[9]) state_d = ROUND;
      end
      ROUND: begin
        diff_d = rnd_res;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      big_q <= '0;
      sml_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      sub_q <= 1'b0;
      nsh_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      big_q <= big_d;
      sml_q <= sml_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      sub_q <= sub_d;
      nsh_q <= nsh_d;
    end
  end
endmodule

// File: tb/tb_bf16_subtractor_seq.sv
// tb_bf16_subtractor_seq: scoreboard bench for bf16_subtractor_seq against an exact-arithmetic RNE model
module tb_bf16_subtractor_seq;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b, diff;
  typedef struct {logic [15:0] d; int lat; int acc;} exp_t;
  exp_t sb[$];
  exp_t t;
  int vec = 0, mis = 0, cyc = 0;
  bit have = 0, rst_seen = 0, rr = 0;
  logic [15:0] held;

  bf16_subtractor_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // exact a - b on scaled integers, rounded to nearest even; a far-smaller operand becomes a 1-unit stand-in
  function automatic logic [15:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
    logic s, nby;
    int ex, ey, d, sh, lo, p, e, rs;
    longint ix, iy, r, mag, q, rem, half;
    nby = ~y[15];
    ex = int'(x[14:7]);
    ey = int'(y[14:7]);
    if (ex == 255) return x;
    if (ey == 255) return {nby, y[14:0]};
    if (ex == 0) return ey == 0 ? 16'h0000 : {nby, y[14:0]};
    if (ey == 0) return x;
    d = ex >= ey ? ex - ey : ey - ex;
    sh = d > 20 ? 20 : d;
    ix = longint'({1'b1, x[6:0]});
    iy = longint'({1'b1, y[6:0]});
    if (ex >= ey) begin
      ix = ix << sh;
      if (d > 20) iy = 1;
      lo = ex - sh;
    end else begin
      iy = iy << sh;
      if (d > 20) ix = 1;
      lo = ey - sh;
    end
    r = (x[15] ? -ix : ix) + (nby ? -iy : iy);
    if (r == 0) return 16'h0000;
    s = r < 0;
    mag = s ? -r : r;
    p = 0;
    for (int k = 0; k < 63; k++) if (mag[k]) p = k;
    e = p + lo - 7;
    if (e < 1) return 16'h0000;
    if (p >= 7) begin
      rs = p - 7;
      q = mag >> rs;
      if (rs > 0) begin
        rem = mag & ((64'(1) << rs) - 1);
        half = 64'(1) << (rs - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end else q = mag << (7 - p);
    if (q == 256) begin
      q = 128;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 7'h00};
    return {s, e[7:0], q[6:0]};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    vec++;
    if (act !== req) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0;
      if (rst_seen) begin
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_diff", diff, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
      end
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      if (out_valid) begin
        if (!have) begin
          if (sb.size() == 0) chk("unexpected_out", diff, 16'hxxxx);
          else begin
            t = sb.pop_front();
            chk("diff", diff, t.d);
            if (t.lat > 0) chk("latency", 16'(cyc - t.acc + 1), 16'(t.lat));
          end
          held = diff;
          have = 1;
        end else begin
          chk("hold_diff", diff, held);
          chk("hold_in_ready", 16'(in_ready), 16'd0);
          chk("hold_busy", 16'(busy), 16'd1);
        end
        if (out_ready) have = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e,
                       input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      if (rr) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!in_ready) begin
      $display("FAIL issue_timeout: in_ready stuck low for a=%h b=%h", x, y);
      $fatal(1);
    end
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    if (push) sb.push_back('{e, lat, cyc});
  endtask

  task automatic drain();
    int n = 0;
    rr = 0;
    out_ready = 1;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      $fatal(1);
    end
  endtask

  initial begin
    logic [15:0] x, y;
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    a = 0;
    b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    issue(16'h4040, 16'h3F80, 16'h4000, 4, 1);
    issue(16'h3F80, 16'hBF80, 16'h4000, 4, 1);
    issue(16'h3F81, 16'h3F80, 16'h3C00, 11, 1);
    issue(16'h3F80, 16'h3F80, 16'h0000, 0, 1);
    issue(16'h3F80, 16'h3B00, 16'h3F80, 5, 1);
    issue(16'h3F80, 16'h3B80, 16'h3F7F, 5, 1);
    issue(16'h7F80, 16'h3F80, 16'h7F80, 2, 1);
    issue(16'h3F80, 16'h7F80, 16'hFF80, 2, 1);
    issue(16'h0000, 16'h3F80, 16'hBF80, 2, 1);
    issue(16'h0001, 16'h0000, 16'h0000, 2, 1);
    issue(16'h7F7F, 16'hFF7F, 16'h7F80, 4, 1);
    issue(16'h0100, 16'h00FF, 16'h0000, 0, 1);
    drain();
    out_ready = 0;
    issue(16'h4040, 16'h3F80, 16'h4000, 4, 1);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1;
    drain();
    issue(16'h3F81, 16'h3F80, 16'h0000, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    issue(16'h4040, 16'h3F80, 16'h4000, 4, 1);
    drain();
    rr = 1;
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      if ($urandom_range(0, 15) == 0) x[14:7] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
      case ($urandom_range(0, 3))
        0: y = 16'($urandom);
        1: y = {1'($urandom), x[14:7] + 8'($urandom_range(0, 6)) - 8'd3, 7'($urandom)};
        2: y = {x[15] ^ 1'($urandom_range(0, 1)), x[14:0] ^ 15'($urandom_range(0, 3))};
        default: y = {1'($urandom), x[14:7] - 8'($urandom_range(8, 30)), 7'($urandom)};
      endcase
      issue(x, y, ref_sub(x, y), 0, 1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/bf16_subtractor_seq.md
Name: bf16_subtractor_seq

Overview:
- Multi-cycle bf16 subtractor: out = a - b.
- Unlike the combinational adder, it fully normalizes after cancellation and rounds round-to-nearest-even (RNE).
- Sits beside the accumulate path and feeds the residual/difference stages of the TPU datapath.
- One operation in flight; valid/ready handshake on both sides.

Parameters:
- MAX_NORM_SHIFT, 11, bound on left-normalize cycles (significand + guard width).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  16  bf16 minuend.
- b  input  16  bf16 subtrahend.
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  consumer accepts result.
- diff  output  16  bf16 result a - b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low. With rst_n low at an edge: state=IDLE, in_ready=1, out_valid=0, diff=16'h0000, busy=0, all datapath registers cleared. Reset mid-operation abandons the operation and produces no output.
- States: IDLE, ALIGN, OP, NORM, ROUND, DONE.
- IDLE: in_valid & in_ready at an edge captures a and b, then goes to ALIGN.
- Operand decode: nb = ~b[15]. Exponent 0 with any fraction is treated as zero (denormals flushed).
- Specials, resolved in ALIGN, then DONE at the next edge. Priority order:
  - a exp=FF: result a.
  - else b exp=FF: result {nb, b[14:0]}.
  - else a zero: {nb, b[14:0]}, or 16'h0000 if b is also zero.
  - else b zero: a.
- Normal ALIGN:
  - Choose the larger magnitude by (exp, frac).
  - Significands are {1, frac, G, R, S}, 11 bits.
  - Shift the smaller significand right by exp_diff; shifted-out bits OR into S.
  - If exp_diff >= 11, the smaller significand becomes 0 with S=1.
- OP:
  - Equal effective signs (a_sign == nb): 12-bit add, sign = a_sign.
  - Otherwise subtract small from large, sign = sign of the larger-magnitude operand (nb if b is larger).
- NORM:
  - Carry bit set: shift right 1, keep sticky, exp+1; goes to ROUND next edge.
  - Result magnitude zero: result 16'h0000, go to DONE.
  - Else, while the hidden bit is clear: shift left 1 and exp-1, one shift per cycle. The hidden bit is checked in the same cycle, so no extra evaluation cycle.
  - If exp would reach 0: flush to 16'h0000, go to DONE.
- ROUND (RNE):
  - Increment when G & (R | S | lsb).
  - Mantissa overflow: exp+1, mantissa 0.
  - exp reaching FF gives {sign, 8'hFF, 7'h0} (±inf).
  - Result registered, then DONE.
- DONE: out_valid=1 with diff stable. out_valid & out_ready at an edge gives IDLE with out_valid=0. in_ready rises the same edge, so no same-cycle accept.
- Latency, accept edge to out_valid high:
  - Specials: 2 edges.
  - Normal, no left shift: 4 edges.
  - Normal with k left shifts: 4+k edges.
- Backpressure: diff and out_valid hold indefinitely while out_ready=0. Inputs are ignored outside IDLE.
- Width: all exponent math is 9-bit to detect under- and overflow.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, diff=0000, busy=0.
- Basic: a=4040 (3.0), b=3F80 (1.0) -> diff=4000, out_valid 4 edges after accept. Then a=3F80, b=BF80 -> diff=4000.
- Cancellation: a=3F81, b=3F80 -> diff=3C00 after 11 edges (7 shifts). a=3F80, b=3F80 -> 0000.
- Tie-to-even: a=3F80, b=3B00 (2^-9) -> diff=3F80. a=3F80, b=3B80 (2^-8) -> 3F7F.
- Specials: a=7F80, b=3F80 -> 7F80; a=3F80, b=7F80 -> FF80; a=0000, b=3F80 -> BF80; a=0001 (denormal), b=0000 -> 0000. Each completes in 2 edges.
- Handshake and reset: hold out_ready=0 for 5 cycles -> diff stable, in_ready=0. Assert rst_n=0 while in NORM -> next cycle IDLE, no out_valid; the following op completes correctly.
